program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit_pkg.sv | 15 +
 rtl/program_counter_unit_if.sv | 29 ++
 rtl/program_counter_unit_pc_adder.sv | 18 +
 rtl/program_counter_unit.sv | 92 +++++++++
 tb/tb_program_counter_unit.sv | 137 +++++++++++++
 5 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the program counter unit.
//   pc_cmd_e             : pc_enable command encodings from instruction decode.
//   DEFAULT_RESET_VECTOR : default address of the reset-vector low byte.
package program_counter_unit_pkg;

  typedef enum logic [1:0] {
    PC_IDLE    = 2'b00,
    PC_INC_ONE = 2'b01,
    PC_LOAD    = 2'b10,
    PC_REL     = 2'b11
  } pc_cmd_e;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;

endpackage

// File: rtl/program_counter_unit_if.sv
// Bus between instruction decode (master) and the program counter unit (slave).
//   pc_enable    : PC command (hold / increment / load / relative add)
//   load_address : target for the load command
//   data_in      : external data bus (vector bytes, signed branch offset)
//   pc           : current program counter
//   bus_address  : address to drive when decode selects the PC source
//   vector_busy  : reset-vector fetch in progress
//   page_cross   : last increment / relative add changed pc[15:8]
interface program_counter_unit_if;

  logic [1:0]  pc_enable;
  logic [15:0] load_address;
  logic [7:0]  data_in;
  logic [15:0] pc;
  logic [15:0] bus_address;
  logic        vector_busy;
  logic        page_cross;

  modport master (
    output pc_enable, load_address, data_in,
    input  pc, bus_address, vector_busy, page_cross
  );

  modport slave (
    input  pc_enable, load_address, data_in,
    output pc, bus_address, vector_busy, page_cross
  );

endinterface

// File: rtl/program_counter_unit_pc_adder.sv
// Combinational 16-bit + signed 8-bit adder, modulo 2^16.
//   base       : current PC
//   offset     : signed 8-bit offset (sign-extended before the add)
//   sum        : base + offset
//   page_cross : sum[15:8] differs from base[15:8]
module pc_adder (
  input  logic [15:0] base,
  input  logic [7:0]  offset,
  output logic [15:0] sum,
  output logic        page_cross
);

  always_comb begin
    sum        = base + {{8{offset[7]}}, offset};
    page_cross = (sum[15:8] != base[15:8]);
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter unit: fetches the 16-bit reset vector (low byte then high
// byte) after reset, then executes hold / increment / load / relative-add
// commands from instruction decode.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset, overrides clk_enable
//   clk_enable : when low, all registers hold
//   bus        : program_counter_unit_if.slave (commands in, PC/status out)
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_enable,
  program_counter_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    S_VEC_LO,
    S_VEC_HI,
    S_RUN
  } state_e;

  state_e      state;
  logic [15:0] pc_q;
  logic        page_cross_q;
  pc_cmd_e     cmd;
  logic [7:0]  add_offset;
  logic [15:0] add_sum;
  logic        add_cross;

  assign cmd = pc_cmd_e'(bus.pc_enable);

  // One adder serves both increment (offset +1) and relative add.
  always_comb begin
    add_offset = bus.data_in;
    if (cmd == PC_INC_ONE) add_offset = 8'h01;
  end

  pc_adder u_pc_adder (
    .base       (pc_q),
    .offset     (add_offset),
    .sum        (add_sum),
    .page_cross (add_cross)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_VEC_LO;
      pc_q         <= '0;
      page_cross_q <= 1'b0;
    end else if (clk_enable) begin
      page_cross_q <= 1'b0;
      case (state)
        S_VEC_LO: begin
          pc_q[7:0] <= bus.data_in;
          state     <= S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_q[15:8] <= bus.data_in;
          state      <= S_RUN;
        end
        S_RUN: begin
          case (cmd)
            PC_INC_ONE, PC_REL: begin
              pc_q         <= add_sum;
              page_cross_q <= add_cross;
            end
            PC_LOAD: pc_q <= bus.load_address;
            default: ;
          endcase
        end
        default: state <= S_VEC_LO;
      endcase
    end
  end

  always_comb begin
    bus.bus_address = pc_q;
    bus.vector_busy = 1'b1;
    case (state)
      S_VEC_LO: bus.bus_address = RESET_VECTOR;
      S_VEC_HI: bus.bus_address = RESET_VECTOR + 16'd1;
      default:  bus.vector_busy = 1'b0;
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.page_cross = page_cross_q;

endmodule

// File: tb/tb_program_counter_unit.sv
module tb_program_counter_unit;

  logic clk;
  logic rst;
  logic clk_enable;
  int   checks   = 0;
  int   failures = 0;

  program_counter_unit_if bus ();

  program_counter_unit #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [1:0]  cmd;
    logic [15:0] load;
    logic [7:0]  din;
    logic [15:0] exp_pc;
    logic [15:0] exp_bus;
    logic        exp_busy;
    logic        exp_cross;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ce, input logic [1:0] cmd,
                       input logic [15:0] load, input logic [7:0] din);
    rst              = r;
    clk_enable       = ce;
    bus.pc_enable    = cmd;
    bus.load_address = load;
    bus.data_in      = din;
  endtask

  // Apply current inputs across one rising edge; outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_bus,
                           input logic e_busy, input logic e_cross);
    check({tag, " pc"}, bus.pc, e_pc);
    check({tag, " bus_address"}, bus.bus_address, e_bus);
    check({tag, " vector_busy"}, {15'd0, bus.vector_busy}, {15'd0, e_busy});
    check({tag, " page_cross"}, {15'd0, bus.page_cross}, {15'd0, e_cross});
  endtask

  function automatic vec_t mk(logic r, logic ce, logic [1:0] cmd, logic [15:0] load,
                              logic [7:0] din, logic [15:0] e_pc, logic [15:0] e_bus,
                              logic e_busy, logic e_cross);
    vec_t v;
    v.rst = r; v.ce = ce; v.cmd = cmd; v.load = load; v.din = din;
    v.exp_pc = e_pc; v.exp_bus = e_bus; v.exp_busy = e_busy; v.exp_cross = e_cross;
    return v;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 2'b01, 16'h0000, 8'h00);

    //               rst  ce   cmd    load      din    pc        bus       busy cross
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 16'h0000, 8'h55, 16'h0000, 16'hFFFC, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b01, 16'h0000, 8'h55, 16'h0000, 16'hFFFC, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 16'h0000, 8'h34, 16'h0034, 16'hFFFD, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 16'h0000, 8'h12, 16'h1234, 16'h1234, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 16'h0000, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 16'h0000, 8'h00, 16'h1235, 16'h1235, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 16'hFFFF, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 16'h10F0, 8'h00, 16'h10F0, 16'h10F0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 8'h20, 16'h1110, 16'h1110, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 8'h80, 16'h1090, 16'h1090, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 8'h00, 16'h1090, 16'h1090, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 16'h0005, 8'h00, 16'h0005, 16'h0005, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 8'hF0, 16'hFFF5, 16'hFFF5, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 16'hC000, 8'h00, 16'hFFF5, 16'hFFF5, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 16'hC000, 8'h00, 16'hC000, 16'hC000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 16'h0000, 8'h00, 16'hC000, 16'hC000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 16'h12FF, 8'h00, 16'h12FF, 16'h12FF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 16'h0000, 8'h00, 16'h1300, 16'h1300, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 8'h7F, 16'h137F, 16'h137F, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 8'hFF, 16'h137E, 16'h137E, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ce, vecs[i].cmd, vecs[i].load, vecs[i].din);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_bus,
                vecs[i].exp_busy, vecs[i].exp_cross);
    end

    // Reset mid-run, stall during the vector fetch, then reset mid-fetch.
    drive(1'b1, 1'b0, 2'b11, 16'h0000, 8'h01);
    step();
    check_all("rst_run", 16'h0000, 16'hFFFC, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 16'hBEEF, 8'hAB);
    step();
    check_all("fetch_lo", 16'h00AB, 16'hFFFD, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b10, 16'hBEEF, 8'hCD);
    step();
    check_all("stall_hi", 16'h00AB, 16'hFFFD, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 16'hBEEF, 8'hCD);
    step();
    check_all("rst_hi", 16'h0000, 16'hFFFC, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 16'h0000, 8'h56);
    step();
    check_all("refetch_lo", 16'h0056, 16'hFFFD, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 16'h0000, 8'h78);
    step();
    check_all("refetch_hi", 16'h7856, 16'h7856, 1'b0, 1'b0);
    // Relative add with negative offset crossing down a page.
    drive(1'b0, 1'b1, 2'b11, 16'h0000, 8'hA0);
    step();
    check_all("rel_back", 16'h77F6, 16'h77F6, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
